// File: rtl/video_pkg.sv
// Shared types and default 1024x768@60 (65 MHz) timing constants for the video timing generator.
package video_pkg;

  typedef logic [15:0] coord_t;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_phase_t;

  localparam int unsigned DEF_H_VISIBLE = 1024;
  localparam int unsigned DEF_H_FRONT   = 24;
  localparam int unsigned DEF_H_SYNC    = 136;
  localparam int unsigned DEF_H_BACK    = 160;
  localparam int unsigned DEF_V_VISIBLE = 768;
  localparam int unsigned DEF_V_FRONT   = 3;
  localparam int unsigned DEF_V_SYNC    = 6;
  localparam int unsigned DEF_V_BACK    = 29;

  localparam int unsigned MAX_AXIS_TOTAL = 65536;

endpackage

// File: rtl/video_axis_counter.sv
// One raster axis: wrapping position counter with a four-phase ACTIVE/FRONT/SYNC/BACK state machine.
module video_axis_counter
  import video_pkg::*;
#(
  parameter int unsigned ACTIVE_LEN = DEF_H_VISIBLE,
  parameter int unsigned FRONT_LEN  = DEF_H_FRONT,
  parameter int unsigned SYNC_LEN   = DEF_H_SYNC,
  parameter int unsigned BACK_LEN   = DEF_H_BACK
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output coord_t      count,
  output axis_phase_t phase,
  output logic        wrap,
  output logic        in_sync
);

  localparam int unsigned TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  // Every phase needs at least one position or the boundary compares below never fire.
  if (TOTAL > MAX_AXIS_TOTAL || ACTIVE_LEN == 0 || FRONT_LEN == 0 ||
      SYNC_LEN == 0 || BACK_LEN == 0) begin : g_bad_timing
    $error("video_axis_counter: axis total must be <= 65536 and every phase non-empty");
  end

  localparam coord_t FRONT_START = coord_t'(ACTIVE_LEN);
  localparam coord_t SYNC_START  = coord_t'(ACTIVE_LEN + FRONT_LEN);
  localparam coord_t BACK_START  = coord_t'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN);
  localparam coord_t LAST        = coord_t'(TOTAL - 1);

  coord_t      count_reg, count_next;
  axis_phase_t phase_reg, phase_next;
  logic        wrap_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      phase_reg <= ACTIVE;
    end else begin
      count_reg <= count_next;
      phase_reg <= phase_next;
    end
  end

  always_comb begin
    count_next = count_reg;
    phase_next = phase_reg;
    wrap_next  = 1'b0;
    if (advance) begin
      if (count_reg == LAST) begin
        count_next = '0;
        phase_next = ACTIVE;
        wrap_next  = 1'b1;
      end else begin
        count_next = count_reg + coord_t'(1);
        // Phase follows the new count so phase_reg always describes count_reg.
        unique case (phase_reg)
          ACTIVE:  if (count_next == FRONT_START) phase_next = FRONT;
          FRONT:   if (count_next == SYNC_START)  phase_next = SYNC;
          SYNC:    if (count_next == BACK_START)  phase_next = BACK;
          default: phase_next = phase_reg;
        endcase
      end
    end
  end

  assign count   = count_reg;
  assign phase   = phase_reg;
  assign wrap    = wrap_next;
  assign in_sync = (phase_reg == SYNC);

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator (coordinates, visible, syncs, line/frame pulses).
// Define VIDEO_TIMING_SYNC_DELAY_EN to delay hsync/vsync by one extra register stage.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT   = DEF_H_FRONT,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BACK    = DEF_H_BACK,
  parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT   = DEF_V_FRONT,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BACK    = DEF_V_BACK,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        visible,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  coord_t      h_count, v_count;
  axis_phase_t h_phase, v_phase;
  logic        h_wrap, h_in_sync, v_in_sync;
  logic        v_wrap_unused;

  video_axis_counter #(
    .ACTIVE_LEN(H_VISIBLE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (1'b1),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap),
    .in_sync (h_in_sync)
  );

  video_axis_counter #(
    .ACTIVE_LEN(V_VISIBLE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (h_wrap),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap_unused),
    .in_sync (v_in_sync)
  );

  // Output stage: every output is a registered decode of the same counter pair,
  // so the first edge after reset presents (0,0).
  coord_t x_reg, y_reg;
  logic   visible_reg, line_start_reg, frame_start_reg, hsync_reg, vsync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg           <= '0;
      y_reg           <= '0;
      visible_reg     <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      hsync_reg       <= ~HSYNC_POL;
      vsync_reg       <= ~VSYNC_POL;
    end else begin
      x_reg           <= h_count;
      y_reg           <= v_count;
      visible_reg     <= (h_phase == ACTIVE) && (v_phase == ACTIVE);
      line_start_reg  <= (h_count == '0);
      frame_start_reg <= (h_count == '0) && (v_count == '0);
      hsync_reg       <= h_in_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_reg       <= v_in_sync ? VSYNC_POL : ~VSYNC_POL;
    end
  end

`ifdef VIDEO_TIMING_SYNC_DELAY_EN
  logic hsync_d_reg, vsync_d_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_d_reg <= ~HSYNC_POL;
      vsync_d_reg <= ~VSYNC_POL;
    end else begin
      hsync_d_reg <= hsync_reg;
      vsync_d_reg <= vsync_reg;
    end
  end

  assign hsync = hsync_d_reg;
  assign vsync = vsync_d_reg;
`else
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;
`endif

  assign x           = x_reg;
  assign y           = y_reg;
  assign visible     = visible_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 1024x768 timing (one line, mid-line reset) and an 8x6 raster (frames, wrap, mid-frame reset).
module tb_video_timing_gen;

`ifdef VIDEO_TIMING_SYNC_DELAY_EN
  localparam int SD = 1;
`else
  localparam int SD = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic [15:0] xa, ya, xb, yb;
  logic        vis_a, hs_a, vs_a, ls_a, fs_a;
  logic        vis_b, hs_b, vs_b, ls_b, fs_b;

  int total = 0;
  int bad   = 0;

  video_timing_gen dut_a (
    .clk(clk), .rst_n(rst_a_n), .x(xa), .y(ya), .visible(vis_a),
    .hsync(hs_a), .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .x(xb), .y(yb), .visible(vis_b),
    .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
  );

  // Vector layout: {x, y, visible, line_start, frame_start, hsync, vsync}
  logic [36:0] got, exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default timing: hsync active-low for x in 1048..1183
  function automatic logic a_hs(input int px);
    return !(px >= 1048 && px <= 1183);
  endfunction

  // Small timing: hsync active-high for x in 5..6, vsync active-low for y == 4
  function automatic logic b_hs(input int px);
    return (px >= 5 && px <= 6);
  endfunction

  function automatic logic b_vs(input int py);
    return !(py == 4);
  endfunction

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (3) step();
    got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
    exp = {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
    got = {xb, yb, vis_b, ls_b, fs_b, hs_b, vs_b};
    exp = {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_b got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    step();
    got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
    exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL first_edge_a got=%h exp=%h", got, exp); end
    $display("test_reset: reset values and first edge checked");
  endtask

  task automatic test_line();
    for (int i = 0; i < 1344; i++) begin
      int px;
      px  = (i == 0) ? 1343 : i - 1;
      got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
      exp = {16'(i), 16'd0, (i < 1024), (i == 0), (i == 0), a_hs((SD != 0) ? px : i), 1'b1};
      total++;
      if (got !== exp) begin bad++; $display("FAIL line_x%0d got=%h exp=%h", i, got, exp); end
      step();
    end
    got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
    exp = {16'd0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL line_wrap got=%h exp=%h", got, exp); end
    $display("test_line: one 1344-pixel line and wrap to y=1 checked");
  endtask

  task automatic test_mid_reset_a();
    repeat (500) step();
    got = {xa, ya, 5'b0};
    exp = {16'd500, 16'd1, 5'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL pre_reset_pos_a got=%h exp=%h", got, exp); end
    #2 rst_a_n = 1'b0;
    #1;
    got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
    exp = {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_reset_a got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_a_n = 1'b1;
    step();
    got = {xa, ya, vis_a, ls_a, fs_a, hs_a, vs_a};
    exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL restart_a got=%h exp=%h", got, exp); end
    $display("test_mid_reset_a: reset at x=500 and restart checked");
  endtask

  task automatic test_small_frames();
    int ex, ey, pex, pey, last_fs;
    @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    step();
    ex = 0; ey = 0; pex = 7; pey = 5; last_fs = -1;
    for (int i = 0; i <= 96; i++) begin
      got = {xb, yb, vis_b, ls_b, fs_b, hs_b, vs_b};
      exp = {16'(ex), 16'(ey), (ex < 4 && ey < 3), (ex == 0), (ex == 0 && ey == 0),
             b_hs((SD != 0) ? pex : ex), b_vs((SD != 0) ? pey : ey)};
      total++;
      if (got !== exp) begin bad++; $display("FAIL small_c%0d got=%h exp=%h", i, got, exp); end
      if (fs_b) begin
        if (last_fs >= 0) begin
          total++;
          if (i - last_fs != 48) begin
            bad++;
            $display("FAIL frame_period got=%0d exp=48", i - last_fs);
          end
        end
        last_fs = i;
      end
      pex = ex;
      pey = ey;
      if (ex == 7) begin
        ex = 0;
        ey = (ey == 5) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      step();
    end
    total++;
    if (last_fs != 96) begin bad++; $display("FAIL last_frame_start got=%0d exp=96", last_fs); end
    $display("test_small_frames: two 8x6 frames and frame period checked");
  endtask

  task automatic test_mid_reset_b();
    @(negedge clk);
    rst_b_n = 1'b0;
    @(negedge clk);
    rst_b_n = 1'b1;
    step();
    repeat (19) step();
    got = {xb, yb, vis_b, 4'b0};
    exp = {16'd3, 16'd2, 1'b1, 4'b0};
    total++;
    if (got !== exp) begin bad++; $display("FAIL pre_reset_pos_b got=%h exp=%h", got, exp); end
    #2 rst_b_n = 1'b0;
    #1;
    got = {xb, yb, vis_b, ls_b, fs_b, hs_b, vs_b};
    exp = {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL async_reset_b got=%h exp=%h", got, exp); end
    step();
    got = {xb, yb, vis_b, ls_b, fs_b, hs_b, vs_b};
    total++;
    if (got !== exp) begin bad++; $display("FAIL reset_hold_b got=%h exp=%h", got, exp); end
    @(negedge clk);
    rst_b_n = 1'b1;
    step();
    got = {xb, yb, vis_b, ls_b, fs_b, hs_b, vs_b};
    exp = {16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    total++;
    if (got !== exp) begin bad++; $display("FAIL restart_b got=%h exp=%h", got, exp); end
    $display("test_mid_reset_b: reset at (3,2), hold and restart checked");
  endtask

  initial begin
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    test_reset();
    test_line();
    test_mid_reset_a();
    test_small_frames();
    test_mid_reset_b();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
